// File: rtl/tx_stream_pts.sv
// tx_stream_pts: handshaked parallel-to-serial transmitter with one-deep holding register and optional bit stuffing
module tx_stream_pts #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1,
    parameter bit IDLE_BIT  = 1,
    parameter bit STUFF_EN  = 1,
    parameter int STUFF_LEN = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_enable,
    input  logic [NUM_BITS-1:0] word_in,
    input  logic                word_valid,
    output logic                word_ready,
    output logic                serial_out,
    output logic                busy,
    output logic                word_done,
    output logic                stuff_bit
);
    localparam int BW = $clog2(NUM_BITS);
    localparam int OW = $clog2(STUFF_LEN + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, STUFF} state_t;
    state_t state;
    logic [NUM_BITS-1:0] hold, shifter, shifted;
    logic hold_full, cur_bit, last_bit, stuff_now;
    logic [BW-1:0] bit_cnt;
    logic [OW-1:0] ones_cnt, ones_next;
    always_comb begin
        cur_bit    = SHIFT_MSB ? shifter[NUM_BITS-1] : shifter[0];
        shifted    = SHIFT_MSB ? {shifter[NUM_BITS-2:0], IDLE_BIT} : {IDLE_BIT, shifter[NUM_BITS-1:1]};
        ones_next  = cur_bit ? ones_cnt + 1'b1 : '0;
        last_bit   = bit_cnt == BW'(NUM_BITS - 1);
        stuff_now  = STUFF_EN && ones_next == OW'(STUFF_LEN);
        serial_out = state == SHIFT ? cur_bit : state == STUFF ? 1'b0 : IDLE_BIT;
        word_ready = !hold_full;
        busy       = state != IDLE || hold_full;
        stuff_bit  = state == STUFF;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shifter   <= {NUM_BITS{IDLE_BIT}};
            bit_cnt   <= '0;
            ones_cnt  <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= state == SHIFT && shift_enable && last_bit;
            if (word_valid && !hold_full) begin
                hold      <= word_in;
                hold_full <= 1'b1;
            end
            case (state)
                IDLE: begin
                    ones_cnt <= '0;
                    if (hold_full) begin
                        shifter   <= hold;
                        hold_full <= 1'b0;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: if (shift_enable) begin
                    shifter  <= shifted;
                    bit_cnt  <= last_bit ? '0 : bit_cnt + 1'b1;
                    ones_cnt <= stuff_now ? '0 : ones_next;
                    if (stuff_now) state <= STUFF;
                    else if (last_bit && hold_full) begin
                        shifter   <= hold;
                        hold_full <= 1'b0;
                    end else if (last_bit) begin
                        ones_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                STUFF: if (shift_enable) begin
                    // bit_cnt wrapped to 0 means the stuff bit followed the word's last data bit
                    if (bit_cnt != '0) state <= SHIFT;
                    else if (hold_full) begin
                        shifter   <= hold;
                        hold_full <= 1'b0;
                        state     <= SHIFT;
                    end else begin
                        ones_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/tx_stream_pts.md
# tx_stream_pts

Parametrised, handshaked parallel-to-serial transmitter for the TX datapath. Words enter over a valid/ready interface into a one-deep holding register and are serialised one bit per `shift_enable` strobe. Shift direction and idle line level are configurable, and optional USB-style bit stuffing is supported. Back-to-back words are sent with no idle gap.

## Interface
- `NUM_BITS`, 8: word width; minimum 2.
- `SHIFT_MSB`, 1: 1 = MSB first, 0 = LSB first.
- `IDLE_BIT`, 1: `serial_out` level when no word is being sent.
- `STUFF_EN`, 1: 1 = insert a 0 after every `STUFF_LEN` consecutive transmitted 1s.
- `STUFF_LEN`, 6: run length that triggers stuffing; minimum 1.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `shift_enable` in 1: bit-period strobe; one bit period ends on each edge where it is high.
- `word_in` in NUM_BITS: parallel data word.
- `word_valid` in 1: `word_in` is valid.
- `word_ready` out 1: holding register empty; equals !hold_full and depends on registers only.
- `serial_out` out 1: serial bit; a function of registers only.
- `busy` out 1: high in SHIFT or STUFF, or while hold_full.
- `word_done` out 1: one-cycle registered pulse after the last data bit period of a word ends.
- `stuff_bit` out 1: high while `serial_out` carries an inserted stuff bit (STUFF state).

## Operation
- Registers: `hold` and `hold_full`; shifter of NUM_BITS bits; `bit_cnt` (clog2(NUM_BITS)); `ones_cnt` (clog2(STUFF_LEN+1)); state (IDLE, SHIFT, STUFF); `word_done` register.
- Accept: on an edge with `word_valid` and `word_ready` high, `hold` ← `word_in` and `hold_full` ← 1.
- Output per state:
  - IDLE: `serial_out` = IDLE_BIT.
  - SHIFT: `serial_out` = shifter[NUM_BITS-1] if SHIFT_MSB, else shifter[0].
  - STUFF: `serial_out` = 0.
- IDLE:
  - `shift_enable` is ignored and `ones_cnt` is held at 0.
  - If `hold_full`, the next edge loads the shifter from `hold`, clears `hold_full`, sets `bit_cnt` = 0 and enters SHIFT, independent of `shift_enable`.
- SHIFT, on `shift_enable`, let `ones_next` = (current bit ? `ones_cnt`+1 : 0):
  - Stuff needed: STUFF_EN and `ones_next` == STUFF_LEN → enter STUFF, `ones_cnt` ← 0. The shifter still advances and `bit_cnt` still increments.
  - Otherwise `ones_cnt` ← `ones_next`; the shifter shifts toward the output end, filling with IDLE_BIT; `bit_cnt` increments.
  - Last bit (`bit_cnt` == NUM_BITS-1): `word_done` pulses next cycle.
  - After the last bit with no stuff needed: if `hold_full`, reload on the same edge (`bit_cnt` ← 0, `hold_full` ← 0, stay in SHIFT); else go to IDLE.
- STUFF, on `shift_enable`:
  - If the word's data bits remain, return to SHIFT.
  - If all data bits are sent, apply the same reload-or-IDLE rule as after the last bit.
- `ones_cnt` carries across word boundaries within a burst and clears on entry to IDLE.
- `word_ready` stays low on the edge where `hold` drains; the refill can be accepted no earlier than the following edge.
- `rst`: state IDLE, `hold_full` 0, `ones_cnt`/`bit_cnt` 0, shifter all IDLE_BIT, `word_done` 0. Any word in flight or in `hold` is discarded without `word_done`. `rst` overrides accept and shift on the same edge.

## Timing
- Outputs after reset: `serial_out` = IDLE_BIT, `word_ready` 1, `busy` 0, `word_done` 0, `stuff_bit` 0.
- Word accepted at edge N while IDLE: first data bit drives `serial_out` from edge N+1.
- Each bit (data or stuff) holds from the edge that starts its period until the next edge with `shift_enable` high.
- Back-to-back words: no IDLE_BIT between the last bit of word k (or its stuff bit) and the first bit of word k+1.
- `word_done` is high for exactly one cycle, the cycle after the last data bit's ending edge.

## Test plan
- Reset: hold `rst` 2 cycles with `word_valid` high → `serial_out` 1, `word_ready` 1, `busy` 0, nothing accepted.
- Defaults, 8'hA5, `shift_enable` every 4 cycles → `serial_out` 1,0,1,0,0,1,0,1, then 1 idle; one `word_done` pulse; `stuff_bit` never high.
- Two 8'hFF words back to back, STUFF_EN=1 → 1111110 11 1111 0 1111 (18 periods); `stuff_bit` high 2 periods; 2 `word_done` pulses; no idle bit between words.
- 8'hFF, STUFF_EN=0 → 8 ones, no stuffing.
- Hold register: present word 2 while word 1 shifts → `word_ready` low until word 2 loads; word 3 held off until then; order preserved.
- SHIFT_MSB=0, 8'h01 → 1,0,0,0,0,0,0,0.
- `rst` asserted after 3 bits with `hold` full → next cycle IDLE, `serial_out` 1, no `word_done`, `word_ready` 1.
